rice_symbol_sequencer: RTL and testbench

Sequencing controller for the Golomb-Rice decode path. It buffers an MSB-first bitstream arriving in W_IN-bit words and drives one `count_lead_one` instance (W_IN input bits, $clog2(W_IN)+1 output bits) to measure unary runs. It accumulates the quotient across words, extracts the K-bit remainder and presents one decoded symbol at a time on a valid/ready output. It sits between the bitstream word source and the downstream symbol consumer.

---
 rtl/rice_symbol_sequencer_if.sv | 31 +++
 rtl/rice_symbol_sequencer.sv | 172 +++++++++++++++++
 tb/tb_rice_symbol_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/rice_symbol_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rice_symbol_sequencer_if                                                   |
// | Bitstream word input and decoded-symbol output handshake bundle.           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface rice_symbol_sequencer_if #(
  parameter int W_IN = 8,
  parameter int K    = 3,
  parameter int W_Q  = 8
);
  logic               flush;
  logic [W_IN-1:0]    in_data;
  logic               in_valid;
  logic               in_ready;
  logic [W_Q+K-1:0]   out_data;
  logic               out_err;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output flush, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_err, out_valid
  );

  modport slave (
    input  flush, in_data, in_valid, out_ready,
    output in_ready, out_data, out_err, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/rice_symbol_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rice_symbol_sequencer                                                      |
// | Golomb-Rice decode sequencer: unary run counting, remainder extraction.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+

module count_lead_one #(
  parameter int W  = 8,
  parameter int OW = $clog2(W) + 1
) (
  input  wire logic [W-1:0]  data,
  output logic      [OW-1:0] count
);
  logic run;

  always_comb begin
    count = '0;
    run   = 1'b1;
    for (int i = W - 1; i >= 0; i--) begin
      if (run && data[i]) begin
        count = count + OW'(1);
      end else begin
        run = 1'b0;
      end
    end
  end
endmodule

module rice_symbol_sequencer #(
  parameter int W_IN = 8,
  parameter int K    = 3,
  parameter int W_Q  = 8
) (
  input  wire logic                clk,
  input  wire logic                rst,
  rice_symbol_sequencer_if.slave   bus
);
  localparam int BW = 2 * W_IN;
  localparam int FW = $clog2(2 * W_IN + 1);
  localparam int CW = $clog2(W_IN) + 1;
  localparam int SW = ((W_Q > CW) ? W_Q : CW) + 1;
  localparam int OW = W_Q + K;
  localparam logic [W_Q-1:0] Q_MAX = {W_Q{1'b1}};

  typedef enum logic [1:0] {
    S_COUNT = 2'd0,
    S_REM   = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  state_t          state_q,     state_d;
  logic [BW-1:0]   buf_q,       buf_d;
  logic [FW-1:0]   fill_q,      fill_d;
  logic [W_Q-1:0]  q_acc_q,     q_acc_d;
  logic            sat_q,       sat_d;
  logic [OW-1:0]   out_data_q,  out_data_d;
  logic            out_err_q,   out_err_d;
  logic            out_valid_q, out_valid_d;

  logic [CW-1:0]   run_len;
  logic [FW-1:0]   consume;
  logic [FW-1:0]   rem_fill;
  logic [BW-1:0]   kept;
  logic [SW-1:0]   sum;
  logic            in_ready;
  logic            accept;

  count_lead_one #(
    .W  (W_IN),
    .OW (CW)
  ) u_clo (
    .data  (buf_q[BW-1 -: W_IN]),
    .count (run_len)
  );

  // Ready depends on registered fill only, so no path from in_valid/out_ready.
  assign in_ready = (fill_q <= FW'(W_IN));
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    q_acc_d     = q_acc_q;
    sat_d       = sat_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    consume     = '0;
    sum         = '0;

    case (state_q)
      S_COUNT: begin
        if (fill_q >= FW'(W_IN)) begin
          if (run_len == CW'(W_IN)) begin
            consume = FW'(W_IN);
          end else begin
            consume = FW'(run_len) + FW'(1);
            state_d = S_REM;
          end
          sum = SW'(q_acc_q) + SW'(run_len);
          if (sum > SW'(Q_MAX)) begin
            q_acc_d = Q_MAX;
            sat_d   = 1'b1;
          end else begin
            q_acc_d = sum[W_Q-1:0];
          end
        end
      end
      S_REM: begin
        if (fill_q >= FW'(K)) begin
          consume     = FW'(K);
          out_data_d  = {q_acc_q, buf_q[BW-1 -: K]};
          out_err_d   = sat_q;
          out_valid_d = 1'b1;
          q_acc_d     = '0;
          sat_d       = 1'b0;
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_COUNT;
        end
      end
      default: state_d = S_COUNT;
    endcase

    // New word lands directly behind whatever survives this cycle's consumption.
    rem_fill = fill_q - consume;
    kept     = buf_q << consume;
    buf_d    = accept ? (kept | ({bus.in_data, {W_IN{1'b0}}} >> rem_fill)) : kept;
    fill_d   = rem_fill + (accept ? FW'(W_IN) : FW'(0));

    if (bus.flush) begin
      buf_d       = '0;
      fill_d      = '0;
      q_acc_d     = '0;
      sat_d       = 1'b0;
      out_valid_d = 1'b0;
      state_d     = S_COUNT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_COUNT;
      buf_q       <= '0;
      fill_q      <= '0;
      q_acc_q     <= '0;
      sat_q       <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      fill_q      <= fill_d;
      q_acc_q     <= q_acc_d;
      sat_q       <= sat_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_valid = out_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_rice_symbol_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rice_symbol_sequencer                                                   |
// | Directed bench for the Rice symbol sequencer (W_IN=8, K=3, W_Q=8).         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_rice_symbol_sequencer;
  localparam int W_IN = 8;
  localparam int K    = 3;
  localparam int W_Q  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rice_symbol_sequencer_if #(.W_IN(W_IN), .K(K), .W_Q(W_Q)) bus ();

  rice_symbol_sequencer #(.W_IN(W_IN), .K(K), .W_Q(W_Q)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_chk = 0;
  int          n_bad = 0;
  logic [7:0]  wq[$];
  logic [11:0] rq[$];
  logic        take = 1'b0;
  logic        ov_prev = 1'b0;
  int          cyc = 0;
  int          n_active = 0;
  int          last_count_cyc = 0;
  int          ov_rise_cyc = 0;
  int          exp_sym[6] = '{21, 14, 5, 10, 7, 0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Word source: presents the queue head, pops it once the DUT has taken it.
  always @(negedge clk) begin
    if (take && wq.size() != 0) void'(wq.pop_front());
    bus.in_valid = (wq.size() != 0);
    bus.in_data  = (wq.size() != 0) ? wq[0] : 8'h00;
    take = bus.in_valid && bus.in_ready && !bus.flush && !rst;
  end

  always @(negedge clk) begin
    if (!rst && !bus.flush) begin
      if (bus.out_valid && bus.out_ready) rq.push_back({bus.out_err, bus.out_data});
      if (32'(dut.state_q) == 0 && dut.fill_q >= 5'd8) begin
        n_active++;
        last_count_cyc = cyc;
      end
      if (bus.out_valid && !ov_prev) ov_rise_cyc = cyc;
    end
    ov_prev = bus.out_valid;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_sym(input int n);
    int b;
    b = 0;
    while (rq.size() < n && b < 200) begin
      step(1);
      b++;
    end
    if (rq.size() < n) chk("sym_timeout", rq.size(), n);
  endtask

  task automatic wait_ov();
    int b;
    b = 0;
    while (!bus.out_valid && b < 100) begin
      step(1);
      b++;
    end
    if (!bus.out_valid) chk("ov_timeout", 0, 1);
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    wq.delete();
    step(1);
    bus.flush = 1'b0;
    rq.delete();
    n_active = 0;
  endtask

  initial begin
    int b;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    // Asynchronous reset asserted mid-cycle
    #3 rst = 1'b1;
    #1;
    chk("rst_ov", bus.out_valid, 0);
    chk("rst_err", bus.out_err, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_inrdy", bus.in_ready, 1);
    step(2);
    chk("rst_hold_ov", bus.out_valid, 0);
    rst = 1'b0;
    step(3);
    chk("idle_ov", bus.out_valid, 0);
    chk("idle_rq", rq.size(), 0);

    // Basic symbol 1101_0110 -> q=2, r=101
    n_active = 0;
    wq.push_back(8'hD6);
    wait_sym(1);
    chk("basic_sym", 32'(rq[0]), 21);
    chk("basic_lat", 32'(ov_rise_cyc - last_count_cyc), 2);
    chk("basic_cnt", n_active, 1);
    chk("basic_fill", 32'(dut.fill_q), 2);

    // Run spanning two full windows
    do_flush();
    wq.push_back(8'hFF);
    wq.push_back(8'hFF);
    wq.push_back(8'h10);
    wait_sym(1);
    chk("multi_sym", 32'(rq[0]), 129);
    chk("multi_cnt", n_active, 3);

    // 256 ones saturates the quotient
    do_flush();
    repeat (32) wq.push_back(8'hFF);
    wq.push_back(8'h00);
    wait_sym(1);
    chk("sat_data", 32'(rq[0][10:0]), 2040);
    chk("sat_err", 32'(rq[0][11]), 1);
    wq.push_back(8'h80);
    wait_sym(2);
    chk("post_sat_err", 32'(rq[1][11]), 0);
    chk("post_sat_data", 32'(rq[1][10:0]), 0);

    // Backpressure with following symbols queued behind
    do_flush();
    bus.out_ready = 1'b0;
    wq.push_back(8'hD6);
    wq.push_back(8'hCB);
    wq.push_back(8'h27);
    wq.push_back(8'h00);
    wait_ov();
    for (int i = 0; i < 5; i++) begin
      chk("bp_data", bus.out_data, 21);
      chk("bp_inrdy", bus.in_ready, 0);
      step(1);
    end
    bus.out_ready = 1'b1;
    wait_sym(6);
    for (int i = 0; i < 6; i++) chk("bp_seq", 32'(rq[i]), exp_sym[i]);

    // Flush in the middle of a run
    do_flush();
    wq.push_back(8'hFF);
    wq.push_back(8'hFF);
    wq.push_back(8'hFF);
    b = 0;
    while (dut.q_acc_q != 8'd8 && b < 50) begin
      step(1);
      b++;
    end
    chk("flush_pre_q", 32'(dut.q_acc_q), 8);
    do_flush();
    chk("flush_fill", 32'(dut.fill_q), 0);
    chk("flush_q", 32'(dut.q_acc_q), 0);
    chk("flush_ov", bus.out_valid, 0);
    wq.push_back(8'h58);
    wait_sym(1);
    chk("flush_sym", 32'(rq[0]), 5);

    // Asynchronous reset with a symbol pending
    do_flush();
    bus.out_ready = 1'b0;
    wq.push_back(8'hD6);
    wait_ov();
    #1 rst = 1'b1;
    #1;
    chk("arst_ov", bus.out_valid, 0);
    chk("arst_data", bus.out_data, 0);
    chk("arst_inrdy", bus.in_ready, 1);
    chk("arst_fill", 32'(dut.fill_q), 0);
    step(1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
